packet_rx_checker: RTL and testbench

//  Downstream consumer of the 13-bit packet stream produced by the packet generator.
//  - Accepts packets on the dd_valid/dd_ready handshake.
//  - Checks sequence number (and parity when enabled).
//  - Buffers accepted packets in a FIFO and presents decoded payload to the sink over
//    out_valid/out_ready.
//  - Reports error/packet statistics.

---
 rtl/pkt_pkg.sv | 31 +++
 rtl/rx_sync_fifo.sv | 60 ++++++
 rtl/packet_rx_checker.sv | 105 ++++++++++
 tb/tb_packet_rx_checker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared packet field layout and FIFO entry types for the packet receive path.
package pkt_pkg;

    localparam int PKT_W    = 13;
    localparam int PAR_BIT  = 12;
    localparam int SEQ_MSB  = 11;
    localparam int SEQ_LSB  = 9;
    localparam int LAST_BIT = 8;
    localparam int PAY_MSB  = 7;
    localparam int PAY_LSB  = 0;
    localparam int SEQ_W    = SEQ_MSB - SEQ_LSB + 1;
    localparam int PAY_W    = PAY_MSB - PAY_LSB + 1;

    typedef struct packed {
        logic             parity;
        logic [SEQ_W-1:0] seq;
        logic             last;
        logic [PAY_W-1:0] payload;
    } pkt_t;

    typedef struct packed {
        logic             last;
        logic [PAY_W-1:0] payload;
    } rx_entry_t;

    // Sequence numbers wrap modulo 2**SEQ_W.
    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible whenever !empty,
// and reads as zero while empty.
module rx_sync_fifo
    import pkt_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = rx_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;
    T              mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    always_comb begin
        dout = '0;
        if (!empty) dout = mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/packet_rx_checker.sv
// Packet receiver: sequence (and optional even-parity) checking, FWFT buffering and
// saturating statistics. Parity checking is enabled by defining PKT_PARITY_CHECK_EN.
module packet_rx_checker
    import pkt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dd_valid,
    input  logic [PKT_W-1:0] packet,
    output logic             dd_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] seq_err_cnt,
    output logic [CNT_W-1:0] par_err_cnt
);

`ifdef PKT_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    pkt_t             pkt_in;
    rx_entry_t        wr_entry, head;
    logic             fifo_full, fifo_empty;
    logic             accept, par_bad, push, seq_bad;
    logic             ready_en_q, ready_en_d;
    logic [SEQ_W-1:0] exp_seq_q, exp_seq_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] seq_err_q, seq_err_d;
    logic [CNT_W-1:0] par_err_q, par_err_d;

    assign pkt_in   = pkt_t'(packet);
    // ready_en_q keeps dd_ready low during reset and rises on the first edge after release.
    assign dd_ready = ready_en_q && !fifo_full;
    assign accept   = dd_valid && dd_ready;
    assign par_bad  = PARITY_EN && (^packet);
    assign push     = accept && !par_bad;
    assign seq_bad  = push && (pkt_in.seq != exp_seq_q);

    assign wr_entry.last    = pkt_in.last;
    assign wr_entry.payload = pkt_in.payload;

    always_comb begin
        ready_en_d = 1'b1;
        exp_seq_d  = exp_seq_q;
        pkt_cnt_d  = pkt_cnt_q;
        seq_err_d  = seq_err_q;
        par_err_d  = par_err_q;
        if (push) begin
            exp_seq_d = seq_next(pkt_in.seq);
            pkt_cnt_d = sat_inc(pkt_cnt_q);
        end
        if (seq_bad)           seq_err_d = sat_inc(seq_err_q);
        if (accept && par_bad) par_err_d = sat_inc(par_err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            exp_seq_q  <= '0;
            pkt_cnt_q  <= '0;
            seq_err_q  <= '0;
            par_err_q  <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            exp_seq_q  <= exp_seq_d;
            pkt_cnt_q  <= pkt_cnt_d;
            seq_err_q  <= seq_err_d;
            par_err_q  <= par_err_d;
        end
    end

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (rx_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_entry),
        .pop   (out_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = head.payload;
    assign out_last    = head.last;
    assign pkt_cnt     = pkt_cnt_q;
    assign seq_err_cnt = seq_err_q;
    assign par_err_cnt = par_err_q;

endmodule

// File: tb/tb_packet_rx_checker.sv
// Randomized bench for packet_rx_checker against a queue-based reference model.
module tb_packet_rx_checker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PKT_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dd_valid = 1'b0;
    logic [12:0]      packet = '0;
    logic             dd_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_last;
    logic [CNT_W-1:0] pkt_cnt, seq_err_cnt, par_err_cnt;

    packet_rx_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .dd_valid    (dd_valid),
        .packet      (packet),
        .dd_ready    (dd_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .pkt_cnt     (pkt_cnt),
        .seq_err_cnt (seq_err_cnt),
        .par_err_cnt (par_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [8:0] m_q[$];
    int         m_exp  = 0;
    int         m_pkt  = 0;
    int         m_seqe = 0;
    int         m_pare = 0;
    bit         m_rdy_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check_all();
        logic [8:0] head;
        head = '0;
        if (m_q.size() > 0) head = m_q[0];
        check_eq("dd_ready", 32'(dd_ready), 32'(m_rdy_en && (m_q.size() < DEPTH)));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check_eq("out_data", 32'(out_data), 32'(head[7:0]));
        check_eq("out_last", 32'(out_last), 32'(head[8]));
        check_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
        check_eq("seq_err_cnt", 32'(seq_err_cnt), 32'(m_seqe));
        check_eq("par_err_cnt", 32'(par_err_cnt), 32'(m_pare));
    endtask

    // Apply one clock edge worth of protocol rules to the model using the driven inputs.
    task automatic model_step();
        bit rdy, acc, bad;
        int seq;
        rdy = m_rdy_en && (m_q.size() < DEPTH);
        acc = dd_valid && rdy;
        if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (acc) begin
            bad = PAR_EN && ((^packet) != 1'b0);
            seq = int'(packet[11:9]);
            if (bad) begin
                m_pare = sat(m_pare);
            end else begin
                if (seq != m_exp) m_seqe = sat(m_seqe);
                m_exp = (seq + 1) % 8;
                m_q.push_back(packet[8:0]);
                m_pkt = sat(m_pkt);
            end
        end
        m_rdy_en = 1'b1;
    endtask

    task automatic drive(input int pv, input int pr, input int ps, input int pp);
        logic [2:0]  seq;
        logic [11:0] body;
        dd_valid  = ($urandom_range(99) < pv);
        out_ready = ($urandom_range(99) < pr);
        seq       = ($urandom_range(99) < ps) ? 3'(m_exp) : 3'($urandom_range(7));
        body      = {seq, 1'($urandom_range(1)), 8'($urandom_range(255))};
        packet    = {(($urandom_range(99) < pp) ? ^body : ~^body), body};
    endtask

    task automatic run_phase(input int n, input int pv, input int pr, input int ps, input int pp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
            drive(pv, pr, ps, pp);
            model_step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_all();
        #2;
        rst       = 1'b1;
        dd_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        m_q.delete();
        m_exp = 0; m_pkt = 0; m_seqe = 0; m_pare = 0;
        m_rdy_en = 1'b0;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        model_step();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b0;
        model_step();
        // In-order streaming, all good
        run_phase(20, 100, 100, 100, 100);
        // Fill with sink stalled, then drain with simultaneous offers at full
        run_phase(12, 100, 0, 100, 100);
        run_phase(10, 100, 100, 100, 100);
        // Sequence errors only
        run_phase(30, 80, 70, 60, 100);
        // Mixed random traffic including parity errors
        run_phase(200, 70, 60, 80, 80);
        // Buffer three entries, then reset mid-operation
        run_phase(3, 100, 0, 100, 100);
        do_reset();
        run_phase(4, 100, 100, 100, 100);
        run_phase(300, 60, 50, 70, 75);
        run_phase(10, 0, 100, 100, 100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
